// File: rtl/wb_pkg.sv
// Shared constants, write-request payload and helpers for the register-file write-port arbiter.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // One register-file write: destination index and data.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
  } wb_req_t;

  // True for writes to the hard-wired zero register.
  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small in-order queue of long-latency write results with per-entry
// destination compare for the hazard unit.
import wb_pkg::*;

module wb_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  wb_req_t                   push_data_i,
  input  logic                      pop_i,
  output wb_req_t                   head_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  input  logic [REG_AW-1:0]         cmp1_addr_i,
  input  logic [REG_AW-1:0]         cmp2_addr_i,
  output logic [DEPTH-1:0]          hit1_o,
  output logic [DEPTH-1:0]          hit2_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for pointers, count and entry-valid bits; pointers wrap naturally.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Per-entry destination match against both decode-stage sources.
  always_comb begin
    hit1_o = '0;
    hit2_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit1_o[i] = valid_q[i] & (mem_q[i].rd == cmp1_addr_i);
      hit2_o[i] = valid_q[i] & (mem_q[i].rd == cmp2_addr_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, long-latency
// results queue and drain in idle slots, starvation forces a one-cycle freeze.
// Optional same-cycle bypass of an empty queue: define WB_ARB_BYPASS_EN.
import wb_pkg::*;

module wb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_we,
  input  logic [REG_AW-1:0]            pipe_rd,
  input  logic [XLEN-1:0]              pipe_wdata,
  input  logic                         mdu_valid,
  output logic                         mdu_ready,
  input  logic [REG_AW-1:0]            mdu_rd,
  input  logic [XLEN-1:0]              mdu_wdata,
  output logic                         rf_we,
  output logic [REG_AW-1:0]            rf_rd,
  output logic [XLEN-1:0]              rf_wdata,
  output logic                         stall_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  input  logic [REG_AW-1:0]            rs1_addr,
  input  logic [REG_AW-1:0]            rs2_addr,
  output logic                         rs1_pending,
  output logic                         rs2_pending
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t               push_req;
  wb_req_t               head;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_cnt;
  logic [FIFO_DEPTH-1:0] hit1, hit2;

  logic                  pipe_act, pipe_grant, head_grant, bypass;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  stall_q, stall_d;

  assign pipe_act = pipe_we & ~is_x0(pipe_rd);
  assign push_req = '{rd: mdu_rd, wdata: mdu_wdata};

  // Port arbitration, handshake and write-port mux.
  always_comb begin
    pipe_grant = pipe_act & ~stall_q & ~rst;
    head_grant = ~fifo_empty & ~pipe_grant & ~rst;
`ifdef WB_ARB_BYPASS_EN
    bypass     = fifo_empty & ~pipe_grant & mdu_valid & ~rst;
`else
    bypass     = 1'b0;
`endif
    mdu_ready  = ~fifo_full & ~rst;
    fifo_push  = mdu_valid & mdu_ready & ~is_x0(mdu_rd) & ~bypass;
    fifo_pop   = head_grant;

    rf_we      = 1'b0;
    rf_rd      = '0;
    rf_wdata   = '0;
    if (pipe_grant) begin
      rf_we    = 1'b1;
      rf_rd    = pipe_rd;
      rf_wdata = pipe_wdata;
    end else if (head_grant) begin
      rf_we    = 1'b1;
      rf_rd    = head.rd;
      rf_wdata = head.wdata;
    end else if (bypass && !is_x0(mdu_rd)) begin
      rf_we    = 1'b1;
      rf_rd    = mdu_rd;
      rf_wdata = mdu_wdata;
    end
  end

  // Starvation counter saturates at the limit and fires a single freeze cycle.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
    stall_d = (starve_q == CNT_W'(STARVE_LIMIT)) & ~stall_q;
  end

  // Starvation and freeze state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (push_req),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .count_o     (fifo_cnt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .cmp1_addr_i (rs1_addr),
    .cmp2_addr_i (rs2_addr),
    .hit1_o      (hit1),
    .hit2_o      (hit2)
  );

  assign stall_o     = stall_q & ~rst;
  assign fifo_count  = rst ? '0 : fifo_cnt;
  assign rs1_pending = ~rst & ~is_x0(rs1_addr) & (|hit1);
  assign rs2_pending = ~rst & ~is_x0(rs2_addr) & (|hit2);

  // The WB stage must stay silent while the port is frozen for a drain.
  a_no_pipe_during_stall: assert property (@(posedge clk) disable iff (rst) !(pipe_act && stall_q));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        stall_o;
  logic [2:0]  fifo_count;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_pending, rs2_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we     (pipe_we),
    .pipe_rd     (pipe_rd),
    .pipe_wdata  (pipe_wdata),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_rd      (mdu_rd),
    .mdu_wdata   (mdu_wdata),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .stall_o     (stall_o),
    .fifo_count  (fifo_count),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_we    = pwe;
    pipe_rd    = prd;
    pipe_wdata = pd;
    mdu_valid  = mv;
    mdu_rd     = mrd;
    mdu_wdata  = md;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd1);
    tick();
    tick();
    #2;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_pend1", 32'(rs1_pending), 32'd0);
    tick();
    rst = 1'b0;

    // Single long-latency push with the pipe idle.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("t1_ready", 32'(mdu_ready), 32'd1);
`ifdef WB_ARB_BYPASS_EN
    chk("t1_byp_we", 32'(rf_we), 32'd1);
    chk("t1_byp_rd", 32'(rf_rd), 32'd5);
    chk("t1_byp_data", rf_wdata, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t1_byp_count", 32'(fifo_count), 32'd0);
    chk("t1_byp_we_after", 32'(rf_we), 32'd0);
`else
    chk("t1_we_same", 32'(rf_we), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_rd", 32'(rf_rd), 32'd5);
    chk("t1_data", rf_wdata, 32'hDEAD_BEEF);
    chk("t1_count1", 32'(fifo_count), 32'd1);
`endif
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t1_count0", 32'(fifo_count), 32'd0);
    chk("t1_idle_we", 32'(rf_we), 32'd0);

    // Fill the queue under a continuously busy pipe; starvation drains it.
    for (int p = 0; p < 4; p++) begin
      tick();
      drive(1'b1, 5'd20, 32'(p), 1'b1, 5'(p + 1), 32'h100 + 32'(p));
      chk("t2_fill_ready", 32'(mdu_ready), 32'd1);
      chk("t2_fill_rd", 32'(rf_rd), 32'd20);
    end
    for (int p = 4; p <= 23; p++) begin
      logic exp_stall;
      exp_stall = (p == 10) || (p == 20);
      tick();
      drive((p <= 20) && !exp_stall, 5'd20, 32'(p), 1'b0, 5'd0, 32'd0);
      chk("t2_stall", 32'(stall_o), 32'(exp_stall));
      if (p == 4) begin
        chk("t2_full_ready", 32'(mdu_ready), 32'd0);
        chk("t2_full_count", 32'(fifo_count), 32'd4);
      end
      if (p == 10) begin
        chk("t2_s1_we", 32'(rf_we), 32'd1);
        chk("t2_s1_rd", 32'(rf_rd), 32'd1);
        chk("t2_s1_data", rf_wdata, 32'h100);
        chk("t2_s1_ready", 32'(mdu_ready), 32'd0);
      end
      if (p == 11) begin
        chk("t2_after_ready", 32'(mdu_ready), 32'd1);
        chk("t2_after_count", 32'(fifo_count), 32'd3);
        chk("t2_after_rd", 32'(rf_rd), 32'd20);
      end
      if (p == 20) chk("t2_s2_rd", 32'(rf_rd), 32'd2);
      if (p == 21) chk("t2_d3_rd", 32'(rf_rd), 32'd3);
      if (p == 22) begin
        chk("t2_d4_rd", 32'(rf_rd), 32'd4);
        chk("t2_d4_count", 32'(fifo_count), 32'd1);
      end
      if (p == 23) chk("t2_empty", 32'(fifo_count), 32'd0);
    end

    // Pending flags track a queued destination until it pops.
    tick();
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    chk("t3_pend_pre", 32'(rs1_pending), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t3_pend1", 32'(rs1_pending), 32'd1);
    chk("t3_pend2", 32'(rs2_pending), 32'd0);
    chk("t3_pop_rd", 32'(rf_rd), 32'd7);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t3_pend1_clr", 32'(rs1_pending), 32'd0);
    chk("t3_pend2_clr", 32'(rs2_pending), 32'd0);
    rs1_addr = 5'd0;

    // Pipe writes to x0 never own the port.
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
    chk("t4_we", 32'(rf_we), 32'd1);
    chk("t4_rd", 32'(rf_rd), 32'd9);
    chk("t4_data", rf_wdata, 32'h99);
    for (int k = 0; k < 2; k++) begin
      tick();
      drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
      chk("t4_x0_we", 32'(rf_we), 32'd0);
    end
    // Zero-destination mdu push is accepted and dropped.
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd0, 32'h55);
    chk("t4_x0_ready", 32'(mdu_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t4_x0_count", 32'(fifo_count), 32'd0);
    chk("t4_x0_mdu_we", 32'(rf_we), 32'd0);

    // Simultaneous push/pop at count 2 across pointer wrap.
    tick();
    drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd10, 32'hA0);
    tick();
    drive(1'b1, 5'd20, 32'h2, 1'b1, 5'd11, 32'hA1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hA2);
    chk("t5_c_s2", 32'(fifo_count), 32'd2);
    chk("t5_rd_s2", 32'(rf_rd), 32'd10);
    chk("t5_data_s2", rf_wdata, 32'hA0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hA3);
    chk("t5_c_s3", 32'(fifo_count), 32'd2);
    chk("t5_rd_s3", 32'(rf_rd), 32'd11);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t5_c_s4", 32'(fifo_count), 32'd2);
    chk("t5_rd_s4", 32'(rf_rd), 32'd12);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t5_c_s5", 32'(fifo_count), 32'd1);
    chk("t5_rd_s5", 32'(rf_rd), 32'd13);
    chk("t5_data_s5", rf_wdata, 32'hA3);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t5_c_s6", 32'(fifo_count), 32'd0);

    // Reset while three entries are queued and the freeze is active.
    for (int t = 0; t < 10; t++) begin
      tick();
      drive(1'b1, 5'd20, 32'(t), (t < 3), 5'(14 + t), 32'hC0 + 32'(t));
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_stall", 32'(stall_o), 32'd1);
    chk("t6_count", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", 32'(rf_we), 32'd0);
    chk("t6_rst_stall", 32'(stall_o), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5);
    chk("t6_held_count", 32'(fifo_count), 32'd0);
    chk("t6_held_stall", 32'(stall_o), 32'd0);
    chk("t6_held_we", 32'(rf_we), 32'd0);
    chk("t6_held_ready", 32'(mdu_ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_post_ready", 32'(mdu_ready), 32'd1);
    chk("t6_post_count", 32'(fifo_count), 32'd0);
    chk("t6_post_we", 32'(rf_we), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_post_we2", 32'(rf_we), 32'd0);
    chk("t6_post_stall", 32'(stall_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
